// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the two-requester register write arbiter:
// default data width, write-count width, FSM state encoding, requester
// index encoding and the round-robin winner selection helper.
package reg_write_arbiter_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned CNT_W      = 8;

   // IDLE: no grant issued last cycle; GRANTED: a grant pulse is out this cycle
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } state_t;

   typedef enum logic {
      REQ_0 = 1'b0,
      REQ_1 = 1'b1
   } req_idx_t;

   // Single eligible requester wins; on a tie the one not granted last wins
   function automatic req_idx_t pick_winner(input logic     elig0,
                                            input logic     elig1,
                                            input req_idx_t last);
      req_idx_t win;
      if (elig0 && elig1) begin
         win = (last == REQ_0) ? REQ_1 : REQ_0;
      end else if (elig1) begin
         win = REQ_1;
      end else begin
         win = REQ_0;
      end
      return win;
   endfunction

endpackage

// File: rtl/byte_reg.sv
// Storage element for the shared register: DATA_W bits, synchronous
// active-high reset, load enable.
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset, clears q
//   load   - capture d at the rising edge
//   d      - data to capture
//   q      - stored value
module byte_reg
   import reg_write_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] r_q;

   // Register with reset priority over load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Single-cycle round-robin arbiter granting two requesters write access
// to one shared DATA_W register.
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - synchronous active-high reset
//   req0/d0   - requester 0 write request (level) and data
//   req1/d1   - requester 1 write request (level) and data
//   lock      - freezes the shared register, no grants while high
//   gnt0/gnt1 - one-cycle pulse: that requester's data was written
//   q         - shared register contents
//   q_valid   - high once any write completed since reset
//   wr_count  - completed writes, modulo 256
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [DATA_W-1:0] d0,
   input  logic              req1,
   input  logic [DATA_W-1:0] d1,
   input  logic              lock,
   output logic              gnt0,
   output logic              gnt1,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   output logic [CNT_W-1:0]  wr_count
);

   state_t            r_state;
   req_idx_t          r_last;
   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_valid;
   logic [CNT_W-1:0]  r_count;

   logic              w_elig0;
   logic              w_elig1;
   logic              w_load;
   req_idx_t          w_winner;
   logic [DATA_W-1:0] w_wdata;

   // A requester holding its grant pulse this cycle sits out the next arbitration
   assign w_elig0  = req0 & ~r_gnt0;
   assign w_elig1  = req1 & ~r_gnt1;
   assign w_winner = pick_winner(w_elig0, w_elig1, r_last);
   assign w_load   = ~lock & (w_elig0 | w_elig1);
   assign w_wdata  = (w_winner == REQ_1) ? d1 : d0;

   byte_reg #(
      .DATA_W (DATA_W)
   ) u_byte_reg (
      .clk   (clk),
      .reset (reset),
      .load  (w_load),
      .d     (w_wdata),
      .q     (q)
   );

   // Grant FSM with registered grant pulses, round-robin pointer and write stats
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_last  <= REQ_1;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         if (w_load) begin
            r_gnt0  <= (w_winner == REQ_0);
            r_gnt1  <= (w_winner == REQ_1);
            r_last  <= w_winner;
            r_valid <= 1'b1;
            r_count <= r_count + CNT_W'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
                  r_state <= ST_GRANTED;
               end
            end
            ST_GRANTED: begin
               // Back-to-back grants only happen when the other requester wins
               r_state <= (w_load && (w_winner != r_last)) ? ST_GRANTED : ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt0     = r_gnt0;
   assign gnt1     = r_gnt1;
   assign q_valid  = r_valid;
   assign wr_count = r_count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus
// randomized traffic checked against a behavioural reference model.
module tb_reg_write_arbiter;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0;
   logic          req1 = 1'b0;
   logic          lock = 1'b0;
   logic [DW-1:0] d0 = '0;
   logic [DW-1:0] d1 = '0;
   logic          gnt0;
   logic          gnt1;
   logic          q_valid;
   logic [DW-1:0] q;
   logic [7:0]    wr_count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_q     = 0;
   int m_valid = 0;
   int m_cnt   = 0;
   int m_last  = 1;
   int m_g[2]  = '{0, 0};

   always #5 clk = ~clk;

   reg_write_arbiter #(.DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .d0       (d0),
      .req1     (req1),
      .d1       (d1),
      .lock     (lock),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .q        (q),
      .q_valid  (q_valid),
      .wr_count (wr_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, then compare all outputs
   task automatic step(input logic rst, input logic r0, input logic [DW-1:0] a0,
                       input logic r1, input logic [DW-1:0] a1, input logic lk);
      int req[2];
      int dat[2];
      int elig[2];
      int win;
      @(negedge clk);
      reset = rst; req0 = r0; d0 = a0; req1 = r1; d1 = a1; lock = lk;
      req[0] = int'(r0); req[1] = int'(r1);
      dat[0] = int'(a0); dat[1] = int'(a1);
      if (rst) begin
         m_q = 0; m_valid = 0; m_cnt = 0; m_last = 1; m_g[0] = 0; m_g[1] = 0;
      end else begin
         win = -1;
         for (int i = 0; i < 2; i++) elig[i] = (!lk && req[i] != 0 && m_g[i] == 0) ? 1 : 0;
         if (elig[0] != 0 && elig[1] != 0) win = 1 - m_last;
         else if (elig[0] != 0)            win = 0;
         else if (elig[1] != 0)            win = 1;
         m_g[0] = 0; m_g[1] = 0;
         if (win >= 0) begin
            m_q = dat[win]; m_g[win] = 1; m_last = win; m_valid = 1;
            m_cnt = (m_cnt + 1) % 256;
         end
      end
      @(posedge clk);
      #1;
      check_eq("q",        32'(q),        32'(m_q));
      check_eq("gnt0",     32'(gnt0),     32'(m_g[0]));
      check_eq("gnt1",     32'(gnt1),     32'(m_g[1]));
      check_eq("q_valid",  32'(q_valid),  32'(m_valid));
      check_eq("wr_count", 32'(wr_count), 32'(m_cnt));
      check_eq("gnt_mutex", 32'(gnt0 & gnt1), 32'd0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
   endtask

   int exp_q[4];
   int exp_g0[4];
   int exp_g1[4];
   int exp_c[4];

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_q", 32'(q), 32'd0);
      check_eq("rst_valid", 32'(q_valid), 32'd0);
      check_eq("rst_cnt", 32'(wr_count), 32'd0);

      // Single write from requester 0
      step(1'b0, 1'b1, 8'd65, 1'b0, 8'd0, 1'b0);
      check_eq("single_q", 32'(q), 32'd65);
      check_eq("single_gnt0", 32'(gnt0), 32'd1);
      check_eq("single_valid", 32'(q_valid), 32'd1);
      check_eq("single_cnt", 32'(wr_count), 32'd1);
      idle();

      // Both requesting from reset: strict alternation starting with 0
      do_reset();
      exp_q  = '{32, 241, 32, 241};
      exp_g0 = '{1, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 8'd32, 1'b1, 8'd241, 1'b0);
         check_eq("rr_q", 32'(q), 32'(exp_q[i]));
         check_eq("rr_gnt0", 32'(gnt0), 32'(exp_g0[i]));
         check_eq("rr_gnt1", 32'(gnt1), 32'(1 - exp_g0[i]));
      end

      // Held lone request is granted every other cycle
      do_reset();
      exp_g1 = '{1, 0, 1, 0};
      exp_c  = '{1, 1, 2, 2};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 8'd0, 1'b1, 8'd73, 1'b0);
         check_eq("hold_gnt1", 32'(gnt1), 32'(exp_g1[i]));
         check_eq("hold_q", 32'(q), 32'd73);
         check_eq("hold_cnt", 32'(wr_count), 32'(exp_c[i]));
      end

      // Lock beats a pending request, serviced once lock falls
      do_reset();
      step(1'b0, 1'b1, 8'd16, 1'b0, 8'd0, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'd25, 1'b0, 8'd0, 1'b1);
         check_eq("lock_q", 32'(q), 32'd16);
         check_eq("lock_gnt0", 32'(gnt0), 32'd0);
      end
      step(1'b0, 1'b1, 8'd25, 1'b0, 8'd0, 1'b0);
      check_eq("unlock_q", 32'(q), 32'd25);
      check_eq("unlock_gnt0", 32'(gnt0), 32'd1);

      // Write counter wraps after 256 writes
      do_reset();
      for (int i = 0; i < 256; i++) begin
         step(1'b0, 1'b1, 8'd69, 1'b0, 8'd0, 1'b0);
         idle();
      end
      check_eq("wrap_cnt", 32'(wr_count), 32'd0);
      check_eq("wrap_q", 32'(q), 32'd69);
      check_eq("wrap_valid", 32'(q_valid), 32'd1);

      // Reset mid-stream overrides a request; first tie afterwards goes to 0
      step(1'b0, 1'b0, 8'd0, 1'b1, 8'd11, 1'b0);
      step(1'b1, 1'b1, 8'd93, 1'b0, 8'd0, 1'b0);
      check_eq("rstreq_q", 32'(q), 32'd0);
      check_eq("rstreq_gnt0", 32'(gnt0), 32'd0);
      check_eq("rstreq_valid", 32'(q_valid), 32'd0);
      step(1'b0, 1'b1, 8'd5, 1'b1, 8'd6, 1'b0);
      check_eq("tie_gnt0", 32'(gnt0), 32'd1);
      check_eq("tie_q", 32'(q), 32'd5);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0),
              1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of the shared register and of each write port.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req0  input  1  requester 0 write request, level.
REQ-005 d0  input  DATA_W  requester 0 write data.
REQ-006 req1  input  1  requester 1 write request, level.
REQ-007 d1  input  DATA_W  requester 1 write data.
REQ-008 lock  input  1  freezes the shared register; no grants while high.
REQ-009 gnt0  output  1  one-cycle pulse: requester 0 data written.
REQ-010 gnt1  output  1  one-cycle pulse: requester 1 data written.
REQ-011 q  output  DATA_W  shared register contents.
REQ-012 q_valid  output  1  high once any write has completed since reset.
REQ-013 wr_count  output  8  number of completed writes, modulo 256.

Function
REQ-014 The block SHALL arbitrate, in a single cycle, between two requesters for the one shared DATA_W-bit register.
REQ-015 At each rising edge with lock=0, eligible requests SHALL be req0 and req1, with a requester that has gntN=1 in that cycle ineligible.
REQ-016 If exactly one request is eligible, that requester SHALL win.
REQ-017 If both are eligible, the requester not named by last_grant SHALL win (round-robin).
REQ-018 On a win, at the same edge: q <= winner's d, gnt of winner <= 1, other gnt <= 0, last_grant <= winner, q_valid <= 1, and wr_count <= wr_count+1.
REQ-019 Write latency SHALL be one edge: data present with req at edge N appears on q and gnt after edge N.
REQ-020 With no eligible request or lock=1, q, last_grant, q_valid and wr_count SHALL hold, and gnt0 and gnt1 SHALL be 0.
REQ-021 gnt0 and gnt1 SHALL never be high together.
REQ-022 Handshake: the requester drops or updates req/d after seeing gnt; a request held continuously SHALL be granted at most every other cycle.
REQ-023 wr_count SHALL wrap from 255 to 0 without a flag.
REQ-024 Lock asserted in the same cycle as requests SHALL win over them; pending requests are serviced after lock falls.
REQ-025 The FSM states SHALL be IDLE (no grant last cycle) and GRANTED (grant pulse this cycle).
REQ-026 IDLE goes to GRANTED on a win; GRANTED goes to GRANTED on a win by the other requester, otherwise to IDLE.

Reset
REQ-027 With reset=1 at an edge: q=0, q_valid=0, gnt0=gnt1=0, wr_count=0, last_grant=1 (requester 0 wins the first tie), FSM=IDLE.
REQ-028 Reset SHALL override lock and requests in the same cycle, including reset mid-stream; any grant in progress is dropped.

Structure
REQ-029 A shared package SHALL hold DATA_W default, the FSM state typedef (IDLE, GRANTED) and the requester-index encoding.
REQ-030 Storage SHALL be one sub-module byte_reg (DATA_W register with synchronous reset and load enable), driven by arbiter-selected data and load.

Verification
REQ-031 Reset, then req0=1 d0=65 for one cycle -> next cycle q=65, gnt0=1, q_valid=1, wr_count=1.
REQ-032 Both requests from reset, d0=32 d1=241 held -> writes in order 32 (gnt0), 241 (gnt1), 32, 241; gnt0 and gnt1 never both high.
REQ-033 req1=1 d1=73 held alone -> gnt1 alternates 1,0,1,0; q=73; wr_count increments every other cycle.
REQ-034 q=16, then lock=1 with req0=1 d0=25 for 3 cycles -> q stays 16, no gnt; lock=0 -> next cycle q=25, gnt0=1.
REQ-035 256 single writes of d0=69 -> wr_count returns to 0; q=69; q_valid stays 1.
REQ-036 reset=1 in the same cycle as req0=1 d0=93 -> q=0, gnt0=0, q_valid=0; first tie afterwards is granted to requester 0.
